// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
package tdm_pkg;

   localparam int NUM_SLOTS = 4;

   typedef logic [1:0] slot_t;

   localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// 2-bit slot counter: steps on enable, realigns to slot 1 on load, flags slot 3.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_n_i,
   input  logic  en_i,
   input  logic  load1_i,
   output slot_t cnt_o,
   output logic  wrap_o
);

   slot_t cnt_q;
   slot_t cnt_d;

   // Load-to-1 wins over stepping: a sync beat is always slot 0, so the next beat is slot 1.
   always_comb begin
      cnt_d = cnt_q;
      if (load1_i) begin
         cnt_d = slot_t'(1);
      end else if (en_i) begin
         cnt_d = cnt_q + slot_t'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = (cnt_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demux4.sv
// Registered 1-to-4 TDM demultiplexer with frame-sync alignment.
//
// state | meaning
// ------+-----------------------------------------------------------
// HUNT  | unaligned; beats without Sync are dropped, Sel held at 0
// RUN   | aligned; beats fill slots in order, frame published on slot 3
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] Din,
   input  logic             Valid_in,
   input  logic             Sync,
   output logic [WIDTH-1:0] Q0,
   output logic [WIDTH-1:0] Q1,
   output logic [WIDTH-1:0] Q2,
   output logic [WIDTH-1:0] Q3,
   output logic             Frame_valid,
   output logic [1:0]       Sel,
   output logic             Sync_err
);

   state_t state_q;
   state_t state_d;

   slot_t sel;
   logic  wrap;
   logic  running;
   logic  sync_beat;
   logic  ctr_en;

   // Slot 3 is never shadowed: it goes straight from Din into Q3.
   logic [WIDTH-1:0] shadow_q [NUM_SLOTS-1];
   logic             shadow_we;
   slot_t            shadow_idx;

   logic [WIDTH-1:0] q_q [NUM_SLOTS];
   logic             frame_done;
   logic             frame_valid_q;
   logic             frame_valid_d;
   logic             sync_err_q;
   logic             sync_err_d;

   assign running   = (state_q == RUN);
   assign sync_beat = Valid_in & Sync;
   assign ctr_en    = Valid_in & running;

   tdm_slot_ctr u_slot_ctr (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .en_i    (ctr_en),
      .load1_i (sync_beat),
      .cnt_o   (sel),
      .wrap_o  (wrap)
   );

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: only a sync beat leaves HUNT; realignment never returns to HUNT.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HUNT:    if (sync_beat) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = HUNT;
      endcase
   end

   // Output decode: frame completion, mid-frame sync error and shadow write steering.
   always_comb begin
      frame_done    = 1'b0;
      sync_err_d    = 1'b0;
      shadow_we     = 1'b0;
      shadow_idx    = sel;
      if (sync_beat) begin
         shadow_we  = 1'b1;
         shadow_idx = '0;
         sync_err_d = running & (sel != '0);
      end else if (ctr_en) begin
         frame_done = wrap;
         shadow_we  = ~wrap;
      end
      frame_valid_d = frame_done;
   end

   // Shadow slots collect the partial frame.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_SLOTS - 1; i++) shadow_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SLOTS - 1; i++) begin
            if (shadow_we && (shadow_idx == slot_t'(i))) shadow_q[i] <= Din;
         end
      end
   end

   // Output frame loads all four slots on one edge so Q never mixes frames.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_SLOTS; i++) q_q[i] <= '0;
      end else if (frame_done) begin
         for (int i = 0; i < NUM_SLOTS - 1; i++) q_q[i] <= shadow_q[i];
         q_q[NUM_SLOTS-1] <= Din;
      end
   end

   // Status pulses, one cycle each.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign Q0          = q_q[0];
   assign Q1          = q_q[1];
   assign Q2          = q_q[2];
   assign Q3          = q_q[3];
   assign Frame_valid = frame_valid_q;
   assign Sync_err    = sync_err_q;
   assign Sel         = sel;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed frames with literal expectations plus a
// randomized stream checked every cycle against a queue-based frame model.
module tb_tdm_demux4;

   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic [W-1:0] Din = '0;
   logic         Valid_in = 1'b0;
   logic         Sync = 1'b0;
   logic [W-1:0] Q0, Q1, Q2, Q3;
   logic         Frame_valid;
   logic [1:0]   Sel;
   logic         Sync_err;

   tdm_demux4 #(.WIDTH(W)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .Din         (Din),
      .Valid_in    (Valid_in),
      .Sync        (Sync),
      .Q0          (Q0),
      .Q1          (Q1),
      .Q2          (Q2),
      .Q3          (Q3),
      .Frame_valid (Frame_valid),
      .Sel         (Sel),
      .Sync_err    (Sync_err)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;
   int fv_cnt   = 0;
   int se_cnt   = 0;
   bit chk_en   = 1'b0;

   // Behavioural model: alignment flag, queue of beats in the current frame,
   // last published frame and the one-cycle pulses.
   bit           m_aligned;
   logic [W-1:0] m_part [$];
   logic [W-1:0] m_q [4];
   bit           m_fv;
   bit           m_se;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic void model_reset();
      m_aligned = 0;
      m_part.delete();
      for (int i = 0; i < 4; i++) m_q[i] = '0;
      m_fv = 0;
      m_se = 0;
   endfunction

   function automatic void model_step(input bit v, input bit s, input logic [W-1:0] d);
      m_fv = 0;
      m_se = 0;
      if (!v) return;
      if (s) begin
         m_se = m_aligned && (m_part.size() != 0);
         m_part.delete();
         m_part.push_back(d);
         m_aligned = 1;
      end else if (m_aligned) begin
         m_part.push_back(d);
         if (m_part.size() == 4) begin
            for (int i = 0; i < 4; i++) m_q[i] = m_part[i];
            m_fv = 1;
            m_part.delete();
         end
      end
   endfunction

   function automatic int model_sel();
      return m_aligned ? m_part.size() : 0;
   endfunction

   // Compare process: every falling edge, DUT against the model.
   always @(negedge CLK) begin
      if (Frame_valid) fv_cnt++;
      if (Sync_err) se_cnt++;
      if (chk_en) begin
         chk("q0", int'(Q0), int'(m_q[0]));
         chk("q1", int'(Q1), int'(m_q[1]));
         chk("q2", int'(Q2), int'(m_q[2]));
         chk("q3", int'(Q3), int'(m_q[3]));
         chk("frame_valid", int'(Frame_valid), int'(m_fv));
         chk("sync_err", int'(Sync_err), int'(m_se));
         chk("sel", int'(Sel), model_sel());
      end
   end

   // One beat: drive, let the edge sample, advance the model, step off the edge.
   task automatic beat(input bit v, input bit s, input logic [W-1:0] d);
      Valid_in = v;
      Sync     = s;
      Din      = d;
      @(posedge CLK);
      if (RST_N) model_step(v, s, d);
      #1;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      model_reset();
      Din = W'($urandom);
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   task automatic chk_q(input string name, input int a, input int b, input int c, input int d);
      chk({name, "_q0"}, int'(Q0), a);
      chk({name, "_q1"}, int'(Q1), b);
      chk({name, "_q2"}, int'(Q2), c);
      chk({name, "_q3"}, int'(Q3), d);
   endtask

   initial begin
      int base_fv;
      int base_se;
      model_reset();
      chk_en = 1'b1;

      // Reset then idle.
      #1;
      do_reset();
      chk("rst_sel", int'(Sel), 0);
      chk_q("rst", 0, 0, 0, 0);
      repeat (3) beat(1'b0, 1'b0, W'($urandom));
      chk_q("idle", 0, 0, 0, 0);
      chk("idle_fv", int'(Frame_valid), 0);

      // Aligned frame A,B,C,D.
      beat(1'b1, 1'b1, 4'hA); chk("al_sel1", int'(Sel), 1);
      beat(1'b1, 1'b0, 4'hB); chk("al_sel2", int'(Sel), 2);
      beat(1'b1, 1'b0, 4'hC); chk("al_sel3", int'(Sel), 3);
      beat(1'b1, 1'b0, 4'hD); chk("al_sel0", int'(Sel), 0);
      chk("al_fv", int'(Frame_valid), 1);
      chk_q("al", 10, 11, 12, 13);
      beat(1'b0, 1'b0, 4'h0);
      chk("al_fv_drop", int'(Frame_valid), 0);

      // Stream with a Valid_in gap, single Sync.
      do_reset();
      base_fv = fv_cnt; base_se = se_cnt;
      beat(1'b1, 1'b1, 4'd1);
      beat(1'b1, 1'b0, 4'd2);
      beat(1'b0, 1'b1, 4'd9);
      beat(1'b1, 1'b0, 4'd3);
      beat(1'b1, 1'b0, 4'd4);
      chk_q("st1", 1, 2, 3, 4);
      beat(1'b1, 1'b0, 4'd5);
      beat(1'b1, 1'b0, 4'd6);
      beat(1'b1, 1'b0, 4'd7);
      beat(1'b1, 1'b0, 4'd8);
      chk_q("st2", 5, 6, 7, 8);
      beat(1'b0, 1'b0, 4'd0);
      chk("st_fv_count", fv_cnt - base_fv, 2);
      chk("st_se_count", se_cnt - base_se, 0);

      // HUNT discard.
      do_reset();
      base_fv = fv_cnt;
      beat(1'b1, 1'b0, 4'd9);
      beat(1'b1, 1'b0, 4'd9);
      chk("hunt_sel", int'(Sel), 0);
      beat(1'b1, 1'b1, 4'd1);
      beat(1'b1, 1'b0, 4'd2);
      beat(1'b1, 1'b0, 4'd3);
      beat(1'b1, 1'b0, 4'd4);
      beat(1'b0, 1'b0, 4'd0);
      chk("hunt_fv_count", fv_cnt - base_fv, 1);
      chk_q("hunt", 1, 2, 3, 4);

      // Mid-frame sync realigns without publishing the partial frame.
      base_fv = fv_cnt; base_se = se_cnt;
      beat(1'b1, 1'b1, 4'd1);
      beat(1'b1, 1'b0, 4'd2);
      beat(1'b1, 1'b1, 4'd5);
      chk("mid_se", int'(Sync_err), 1);
      chk("mid_sel", int'(Sel), 1);
      chk_q("mid_hold", 1, 2, 3, 4);
      beat(1'b1, 1'b0, 4'd6);
      beat(1'b1, 1'b0, 4'd7);
      beat(1'b1, 1'b0, 4'd8);
      chk_q("mid_new", 5, 6, 7, 8);
      beat(1'b0, 1'b0, 4'd0);
      chk("mid_fv_count", fv_cnt - base_fv, 1);
      chk("mid_se_count", se_cnt - base_se, 1);

      // Reset mid-frame drops alignment.
      do_reset();
      base_fv = fv_cnt;
      beat(1'b1, 1'b1, 4'd1);
      beat(1'b1, 1'b0, 4'd2);
      do_reset();
      beat(1'b1, 1'b0, 4'd3);
      beat(1'b1, 1'b0, 4'd4);
      beat(1'b1, 1'b0, 4'd5);
      beat(1'b1, 1'b0, 4'd6);
      beat(1'b0, 1'b0, 4'd0);
      chk("rmid_fv_count", fv_cnt - base_fv, 0);
      chk_q("rmid", 0, 0, 0, 0);

      // Randomized stream with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            beat(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), W'($urandom));
         end
      end
      beat(1'b0, 1'b0, 4'd0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
